// File: rtl/riscv_pkg.sv
// Shared definitions for the fetch front end.
//   NOP_INSTR        : word presented on instr when nothing has been fetched yet
//   RESET_PC_DEFAULT : default fetch start address after reset
//   fetch_state_t    : fetch controller states
package riscv_pkg;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO used both for fetched {instr, pc} words and for the
// queue of PCs belonging to requests still in flight at the memory.
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   push, wdata     : write an entry (ignored when full unless popping too)
//   pop             : drop the head entry (ignored when empty)
//   flush           : empty the FIFO (wins over push/pop)
//   rdata           : head entry, valid while !empty
//   full, empty     : status
//   count           : current occupancy
module fetch_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 64
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       flush,
    input  logic [WIDTH-1:0]           wdata,
    output logic [WIDTH-1:0]           rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_reg [DEPTH];
    logic [PW-1:0]    rd_ptr_reg;
    logic [PW-1:0]    wr_ptr_reg;
    logic [CW-1:0]    count_reg;
    logic             do_push;
    logic             do_pop;

    assign full  = (count_reg == CW'(DEPTH));
    assign empty = (count_reg == '0);
    assign count = count_reg;
    assign rdata = mem_reg[rd_ptr_reg];

    // A push into a full FIFO is allowed when the head leaves in the same cycle.
    assign do_push = push && (!full || pop);
    assign do_pop  = pop && !empty;

    // Storage carries no reset; only pointers and the count do.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_reg[wr_ptr_reg] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + PW'(1);
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + PW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + CW'(1);
                2'b01:   count_reg <= count_reg - CW'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch unit. Holds the PC, issues word requests to instruction
// memory under a credit limit, buffers in-order responses with their PCs and
// hands {instr, instr_pc} to the decoder over a valid/ready handshake.
// A redirect flushes buffered words, restarts at redirect_pc and discards the
// responses of requests that were already in flight.
// Ports:
//   clk, rst                        : clock, synchronous active-high reset
//   imem_req_valid/ready/addr       : request channel to instruction memory
//   imem_rsp_valid/data             : in-order response channel
//   instr_valid/ready, instr, instr_pc : decoder channel
//   redirect, redirect_pc           : taken branch/jump restart
module instr_fetch
    import riscv_pkg::*;
#(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = ADDR_WIDTH'(RESET_PC_DEFAULT),
    parameter int                    FIFO_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  imem_req_valid,
    input  logic                  imem_req_ready,
    output logic [ADDR_WIDTH-1:0] imem_req_addr,
    input  logic                  imem_rsp_valid,
    input  logic [DATA_WIDTH-1:0] imem_rsp_data,
    output logic                  instr_valid,
    input  logic                  instr_ready,
    output logic [DATA_WIDTH-1:0] instr,
    output logic [ADDR_WIDTH-1:0] instr_pc,
    input  logic                  redirect,
    input  logic [ADDR_WIDTH-1:0] redirect_pc
);

    localparam int              CW      = $clog2(FIFO_DEPTH + 1);
    localparam int              CW1     = CW + 1;
    localparam int              EW      = DATA_WIDTH + ADDR_WIDTH;
    localparam logic [CW:0]     DEPTH_C = CW1'(FIFO_DEPTH);

    fetch_state_t          state_reg;
    logic [ADDR_WIDTH-1:0] pc_reg;
    logic [CW-1:0]         drop_reg;
    logic [CW-1:0]         drop_next;
    logic [DATA_WIDTH-1:0] last_instr_reg;
    logic [ADDR_WIDTH-1:0] last_pc_reg;

    logic [CW-1:0]         occupancy;
    logic [CW-1:0]         inflight;
    logic [CW:0]           credit_used;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  pcq_full;
    logic                  pcq_empty;
    logic [EW-1:0]         head_entry;
    logic [ADDR_WIDTH-1:0] pcq_head;
    logic                  req_fire;
    logic                  pop_instr;
    logic                  push_rsp;
    logic                  unused_ok;

    // Buffered words plus outstanding requests never exceed the FIFO size,
    // so a response always has a free slot waiting for it.
    assign credit_used    = {1'b0, occupancy} + {1'b0, inflight};
    assign imem_req_valid = (state_reg != IDLE) && !redirect && (credit_used < DEPTH_C);
    assign imem_req_addr  = pc_reg;
    assign req_fire       = imem_req_valid && imem_req_ready;

    assign instr_valid = !fifo_empty;
    assign pop_instr   = instr_valid && instr_ready;
    assign instr       = fifo_empty ? last_instr_reg : head_entry[EW-1:ADDR_WIDTH];
    assign instr_pc    = fifo_empty ? last_pc_reg    : head_entry[ADDR_WIDTH-1:0];

    // A response in a redirect cycle belongs to the old path, as do all
    // responses while drop is non-zero.
    assign push_rsp = imem_rsp_valid && !redirect && (drop_reg == '0);

    always_comb begin
        drop_next = drop_reg;
        if (redirect) begin
            drop_next = inflight - CW'(imem_rsp_valid);
        end else if (imem_rsp_valid && (drop_reg != '0)) begin
            drop_next = drop_reg - CW'(1);
        end
    end

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (EW)
    ) u_data_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_rsp),
        .pop   (pop_instr),
        .flush (redirect),
        .wdata ({imem_rsp_data, pcq_head}),
        .rdata (head_entry),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (occupancy)
    );

    // One entry per accepted request; its count is the in-flight counter.
    // Never flushed: stale entries retire with their (dropped) responses.
    fetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ADDR_WIDTH)
    ) u_pc_queue (
        .clk   (clk),
        .rst   (rst),
        .push  (req_fire),
        .pop   (imem_rsp_valid),
        .flush (1'b0),
        .wdata (pc_reg),
        .rdata (pcq_head),
        .full  (pcq_full),
        .empty (pcq_empty),
        .count (inflight)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            pc_reg         <= RESET_PC;
            drop_reg       <= '0;
            last_instr_reg <= DATA_WIDTH'(NOP_INSTR);
            last_pc_reg    <= RESET_PC;
        end else begin
            drop_reg <= drop_next;
            // Track the presented head so instr holds once the FIFO empties.
            if (!fifo_empty) begin
                last_instr_reg <= head_entry[EW-1:ADDR_WIDTH];
                last_pc_reg    <= head_entry[ADDR_WIDTH-1:0];
            end
            if (redirect) begin
                pc_reg    <= {redirect_pc[ADDR_WIDTH-1:2], 2'b00};
                state_reg <= (drop_next != '0) ? DRAIN : FETCH;
            end else begin
                if (req_fire) begin
                    pc_reg <= pc_reg + ADDR_WIDTH'(4);
                end
                case (state_reg)
                    IDLE:    state_reg <= FETCH;
                    DRAIN:   state_reg <= (drop_next == '0) ? FETCH : DRAIN;
                    default: state_reg <= state_reg;
                endcase
            end
        end
    end

    assign unused_ok = &{1'b0, fifo_full, pcq_full, pcq_empty, redirect_pc[1:0]};

endmodule

// File: tb/tb_instr_fetch.sv
module tb_instr_fetch;

    localparam logic [31:0] TB_RESET_PC = 32'hFFFF_FFF8;
    localparam int          DEPTH       = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data  = '0;
    logic        instr_valid;
    logic        instr_ready    = 1'b0;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        redirect       = 1'b0;
    logic [31:0] redirect_pc    = '0;

    instr_fetch #(
        .DATA_WIDTH (32),
        .ADDR_WIDTH (32),
        .RESET_PC   (TB_RESET_PC),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .redirect       (redirect),
        .redirect_pc    (redirect_pc)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        int          due;
    } mreq_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] data;
    } word_t;

    mreq_t       mem_q[$];
    word_t       exp_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    int          ready_pct = 100, iready_pct = 100, redir_pm = 0;
    int          lat_min = 1, lat_max = 1;
    int          acc_since_rst = 0;
    logic [31:0] first_addr [3];
    logic [31:0] fetch_pc = TB_RESET_PC;
    logic        hold_prev = 1'b0;
    logic [31:0] prev_instr, prev_pc;
    logic        redir_pending = 1'b0;
    logic [31:0] redir_target;

    // Memory contents: a fixed scramble of the word address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Advance one cycle and drive all inputs for it.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (!rst && mem_q.size() > 0 && mem_q[0].due <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_q[0].data;
            mem_q.delete(0);
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = $urandom;
        end
        imem_req_ready = ($urandom_range(0, 99) < ready_pct);
        instr_ready    = ($urandom_range(0, 99) < iready_pct);
        if ($urandom_range(0, 999) < redir_pm) begin
            redirect    = 1'b1;
            redirect_pc = $urandom & 32'h0000_1FFF;
        end else begin
            redirect    = 1'b0;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        @(negedge clk);
        check("rst_instr_valid", instr_valid, 0);
        check("rst_req_valid", imem_req_valid, 0);
        check("rst_instr", instr, 32'h0000_0013);
        check("rst_instr_pc", instr_pc, TB_RESET_PC);
        tick();
        rst = 1'b0;
        redirect = 1'b0;
    endtask

    // Memory side: accept requests, check the fetch address sequence, record
    // the expected decoder word for every accepted request.
    always @(negedge clk) begin
        if (rst) begin
            mem_q.delete();
            fetch_pc      = TB_RESET_PC;
            acc_since_rst = 0;
        end else begin
            if (imem_req_valid && imem_req_ready) begin
                mreq_t m;
                word_t w;
                check("req_addr", imem_req_addr, fetch_pc);
                m.addr = imem_req_addr;
                m.data = mem_word(imem_req_addr);
                m.due  = cyc + $urandom_range(lat_min, lat_max);
                mem_q.push_back(m);
                w.pc   = fetch_pc;
                w.data = mem_word(fetch_pc);
                exp_q.push_back(w);
                if (acc_since_rst < 3) first_addr[acc_since_rst] = imem_req_addr;
                acc_since_rst++;
                fetch_pc = fetch_pc + 32'd4;
            end
            if (redirect) fetch_pc = {redirect_pc[31:2], 2'b00};
        end
    end

    // Decoder side: compare each consumed word against the scoreboard.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            hold_prev     = 1'b0;
            redir_pending = 1'b0;
        end else begin
            if (hold_prev) begin
                check("hold_stable", {instr_valid, instr, instr_pc}, {1'b1, prev_instr, prev_pc});
            end
            if (instr_valid && instr_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_word_pc", instr_pc, 32'hDEAD_BEEF);
                end else begin
                    word_t e;
                    e = exp_q.pop_front();
                    check("word_pc", instr_pc, e.pc);
                    check("word_data", instr, e.data);
                end
                if (redir_pending) begin
                    check("post_redirect_pc", instr_pc, redir_target);
                    redir_pending = 1'b0;
                end
            end
            if (redirect) begin
                exp_q.delete();
                redir_pending = 1'b1;
                redir_target  = {redirect_pc[31:2], 2'b00};
            end
            hold_prev  = instr_valid && !instr_ready && !redirect;
            prev_instr = instr;
            prev_pc    = instr_pc;
        end
    end

    initial begin
        int n;
        logic found;

        // 1: streaming, 1-cycle memory; first word 3 cycles after reset release.
        ready_pct = 100; iready_pct = 100; redir_pm = 0; lat_min = 1; lat_max = 1;
        tick();
        do_reset();
        n = 0;
        while (n < 20) begin
            @(negedge clk);
            if (instr_valid) break;
            tick();
            n++;
        end
        check("first_valid_latency", n, 3);
        for (int i = 0; i < 20 && acc_since_rst < 3; i++) tick();
        check("wrap_addr0", first_addr[0], 32'hFFFF_FFF8);
        check("wrap_addr1", first_addr[1], 32'hFFFF_FFFC);
        check("wrap_addr2", first_addr[2], 32'h0000_0000);
        for (int i = 0; i < 20; i++) tick();

        // 2: decoder stalled; only FIFO_DEPTH requests may be accepted.
        iready_pct = 0;
        do_reset();
        for (int i = 0; i < 12; i++) tick();
        @(negedge clk);
        check("stall_accepts", acc_since_rst, DEPTH);
        iready_pct = 100;
        for (int i = 0; i < 10; i++) tick();

        // 3: 3-cycle memory, two in flight, redirect to 0x100.
        lat_min = 3; lat_max = 3;
        do_reset();
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (acc_since_rst >= 2) break;
            tick();
        end
        check("drain_setup_accepts", acc_since_rst, 2);
        tick();
        redirect = 1'b1; redirect_pc = 32'h0000_0100;
        for (int i = 0; i < 30 && (redir_pending || redirect); i++) tick();
        check("drain_resumed", redir_pending, 0);

        // 4: redirect to 0x103 with same-cycle response and handshake.
        lat_min = 1; lat_max = 1;
        do_reset();
        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            tick();
            if (instr_valid && imem_rsp_valid && instr_ready) begin
                redirect = 1'b1; redirect_pc = 32'h0000_0103; found = 1'b1;
            end
        end
        check("redir_same_cycle_found", found, 1);
        for (int i = 0; i < 30 && (redir_pending || redirect); i++) tick();
        check("redir103_resumed", redir_pending, 0);

        // 6: reset with a full FIFO, then restart at RESET_PC.
        iready_pct = 0;
        for (int i = 0; i < 10; i++) tick();
        @(negedge clk);
        check("full_before_reset", instr_valid, 1);
        tick();
        do_reset();
        iready_pct = 100;
        for (int i = 0; i < 20 && acc_since_rst < 1; i++) tick();
        check("restart_addr", first_addr[0], TB_RESET_PC);

        // Randomised traffic with redirects.
        for (int blk = 0; blk < 6; blk++) begin
            ready_pct  = $urandom_range(40, 100);
            iready_pct = $urandom_range(30, 100);
            redir_pm   = $urandom_range(10, 80);
            lat_min    = $urandom_range(1, 2);
            lat_max    = lat_min + $urandom_range(0, 3);
            for (int i = 0; i < 400; i++) tick();
            if (blk == 3) do_reset();
        end
        redir_pm = 0; iready_pct = 100; ready_pct = 100;
        for (int i = 0; i < 20; i++) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

endmodule
